// File: rtl/bpf_code_pkg.sv
// Shared definitions for the packet-filter code RAM, its loader and the CPU fetch stage.
package bpf_code_pkg;

    localparam int unsigned CODE_ADDR_WIDTH = 10;
    localparam int unsigned CODE_DATA_WIDTH = 64;

    typedef enum logic [2:0] {
        EMPTY,
        WAIT_CPU,
        LOAD,
        READY,
        ERROR
    } load_state_e;

endpackage

// File: rtl/code_loader.sv
// Owns the code RAM write port: streams a host program into RAM from address 0
// and gates CPU fetches until a complete program is resident.
module code_loader
    import bpf_code_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = CODE_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = CODE_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    input  logic                  cpu_idle,
    input  logic                  cpu_rd_en,
    input  logic [ADDR_WIDTH-1:0] cpu_rd_addr,
    output logic                  code_valid,
    output logic [ADDR_WIDTH:0]   prog_len,
    output logic                  load_err,
    output logic                  fetch_oob,
    output logic                  ram_ce,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr
);

    localparam int unsigned LEN_WIDTH = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

    load_state_e           state;
    logic [ADDR_WIDTH-1:0] wr_cnt;
    logic                  valid_pend;
    logic                  accept;
    logic                  do_write;

    assign in_ready    = (state == LOAD);
    assign accept      = in_valid & in_ready;
    assign do_write    = accept & ~load_start;
    assign ram_rd_addr = cpu_rd_addr;
    assign ram_ce      = ram_wr_en | (cpu_rd_en & code_valid);

    // code_valid rises one cycle after the last write so the final word is resident first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            wr_cnt      <= '0;
            valid_pend  <= 1'b0;
            code_valid  <= 1'b0;
            prog_len    <= '0;
            load_err    <= 1'b0;
            fetch_oob   <= 1'b0;
            ram_wr_en   <= 1'b0;
            ram_wr_addr <= '0;
            ram_wr_data <= '0;
        end else begin
            fetch_oob  <= cpu_rd_en & code_valid & ({1'b0, cpu_rd_addr} >= prog_len);
            ram_wr_en  <= do_write;
            valid_pend <= 1'b0;
            if (do_write) begin
                ram_wr_addr <= wr_cnt;
                ram_wr_data <= in_data;
            end
            if (valid_pend) begin
                code_valid <= 1'b1;
            end

            if (load_start) begin
                state      <= WAIT_CPU;
                wr_cnt     <= '0;
                code_valid <= 1'b0;
                load_err   <= 1'b0;
            end else begin
                case (state)
                    WAIT_CPU: begin
                        if (cpu_idle) begin
                            state <= LOAD;
                        end
                    end
                    LOAD: begin
                        if (accept) begin
                            if (in_last) begin
                                state      <= READY;
                                prog_len   <= LEN_WIDTH'(wr_cnt) + LEN_WIDTH'(1);
                                valid_pend <= 1'b1;
                            end else if (wr_cnt == LAST_ADDR) begin
                                state      <= ERROR;
                                load_err   <= 1'b1;
                                code_valid <= 1'b0;
                                prog_len   <= '0;
                            end else begin
                                wr_cnt <= wr_cnt + ADDR_WIDTH'(1);
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_code_loader.sv
// Directed bench for code_loader with a cycle-level reference model and a behavioural code RAM.
module tb_code_loader;
    import bpf_code_pkg::*;

    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 64;
    localparam int unsigned LW    = AW + 1;
    localparam int          DEPTH = 16;

    localparam int M_EMPTY = 0;
    localparam int M_WAIT  = 1;
    localparam int M_LOAD  = 2;
    localparam int M_READY = 3;
    localparam int M_ERROR = 4;

    logic          clk         = 1'b0;
    logic          rst_n       = 1'b1;
    logic          load_start  = 1'b0;
    logic          in_valid    = 1'b0;
    logic [DW-1:0] in_data     = '0;
    logic          in_last     = 1'b0;
    logic          cpu_idle    = 1'b0;
    logic          cpu_rd_en   = 1'b0;
    logic [AW-1:0] cpu_rd_addr = '0;

    logic          in_ready;
    logic          code_valid;
    logic [AW:0]   prog_len;
    logic          load_err;
    logic          fetch_oob;
    logic          ram_ce;
    logic          ram_wr_en;
    logic [AW-1:0] ram_wr_addr;
    logic [DW-1:0] ram_wr_data;
    logic [AW-1:0] ram_rd_addr;

    int checks   = 0;
    int failures = 0;

    code_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .cpu_idle(cpu_idle), .cpu_rd_en(cpu_rd_en), .cpu_rd_addr(cpu_rd_addr),
        .code_valid(code_valid), .prog_len(prog_len), .load_err(load_err),
        .fetch_oob(fetch_oob), .ram_ce(ram_ce), .ram_wr_en(ram_wr_en),
        .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data), .ram_rd_addr(ram_rd_addr)
    );

    always #5 clk = ~clk;

    // Code RAM the parent would instantiate: 1-cycle read, clock-enabled
    logic [DW-1:0] ram_mem [DEPTH];
    logic [DW-1:0] rd_data;
    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_wr_en) ram_mem[ram_wr_addr] <= ram_wr_data;
            rd_data <= ram_mem[ram_rd_addr];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: loader mode, fill count and the expected registered outputs
    int            m_mode  = M_EMPTY;
    int            m_cnt   = 0;
    bit            m_pend  = 1'b0;
    bit            m_take;
    logic          e_valid = 1'b0;
    logic          e_err   = 1'b0;
    logic          e_oob   = 1'b0;
    logic          e_wen   = 1'b0;
    logic [AW:0]   e_len   = '0;
    logic [AW-1:0] e_waddr = '0;
    logic [DW-1:0] e_wdata = '0;
    logic [DW-1:0] prog_mem [DEPTH];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = M_EMPTY; m_cnt = 0; m_pend = 1'b0;
            e_valid = 1'b0; e_err = 1'b0; e_oob = 1'b0; e_wen = 1'b0;
            e_len = '0; e_waddr = '0; e_wdata = '0;
        end else begin
            m_take = (m_mode == M_LOAD) && in_valid;
            e_oob  = cpu_rd_en && e_valid && (int'(cpu_rd_addr) >= int'(e_len));
            e_wen  = m_take && !load_start;
            if (e_wen) begin
                e_waddr = AW'(m_cnt);
                e_wdata = in_data;
                prog_mem[m_cnt] = in_data;
            end
            if (m_pend) e_valid = 1'b1;
            m_pend = 1'b0;
            if (load_start) begin
                m_mode = M_WAIT; m_cnt = 0; e_valid = 1'b0; e_err = 1'b0;
            end else if (m_mode == M_WAIT) begin
                if (cpu_idle) m_mode = M_LOAD;
            end else if (m_take) begin
                if (in_last) begin
                    m_mode = M_READY; e_len = LW'(m_cnt + 1); m_pend = 1'b1;
                end else if (m_cnt == DEPTH - 1) begin
                    m_mode = M_ERROR; e_err = 1'b1; e_valid = 1'b0; e_len = '0;
                end else begin
                    m_cnt++;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("in_ready",    64'(in_ready),    64'(m_mode == M_LOAD));
        check("code_valid",  64'(code_valid),  64'(e_valid));
        check("prog_len",    64'(prog_len),    64'(e_len));
        check("load_err",    64'(load_err),    64'(e_err));
        check("fetch_oob",   64'(fetch_oob),   64'(e_oob));
        check("ram_wr_en",   64'(ram_wr_en),   64'(e_wen));
        check("ram_wr_addr", 64'(ram_wr_addr), 64'(e_waddr));
        check("ram_wr_data", ram_wr_data,      e_wdata);
        check("ram_ce",      64'(ram_ce),      64'(e_wen | (cpu_rd_en & e_valid)));
        check("ram_rd_addr", 64'(ram_rd_addr), 64'(cpu_rd_addr));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic last);
        bit done;
        done = 1'b0;
        in_valid = 1'b1; in_data = d; in_last = last;
        for (int i = 0; i < 40 && !done; i++) begin
            done = in_ready;
            tick();
        end
        check("send_handshake", 64'(done), 64'd1);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic start_load();
        load_start = 1'b1; cpu_idle = 1'b1;
        tick();
        load_start = 1'b0;
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},   64'(in_ready),    64'd0);
        check({tag, "_code_valid"}, 64'(code_valid),  64'd0);
        check({tag, "_prog_len"},   64'(prog_len),    64'd0);
        check({tag, "_load_err"},   64'(load_err),    64'd0);
        check({tag, "_fetch_oob"},  64'(fetch_oob),   64'd0);
        check({tag, "_ram_ce"},     64'(ram_ce),      64'd0);
        check({tag, "_ram_wr_en"},  64'(ram_wr_en),   64'd0);
        check({tag, "_ram_wr_addr"},64'(ram_wr_addr), 64'd0);
        check({tag, "_ram_wr_data"},ram_wr_data,      64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        #2 check_reset_outputs("por");
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        tick();

        // 3-word program, then fetch inside and just past the end
        start_load();
        check("load_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 3; i++) send(64'hC0DE_0000_0000_0000 + 64'(i), i == 2);
        check("len3", 64'(prog_len), 64'd3);
        check("valid_t1", 64'(code_valid), 64'd0);
        tick();
        check("valid_t2", 64'(code_valid), 64'd1);
        cpu_rd_en = 1'b1; cpu_rd_addr = 4'd2;
        tick();
        check("rd_word2", rd_data, 64'hC0DE_0000_0000_0002);
        check("rd_word2_model", rd_data, prog_mem[2]);
        check("oob_addr2", 64'(fetch_oob), 64'd0);
        cpu_rd_addr = 4'd3;
        tick();
        check("oob_addr3", 64'(fetch_oob), 64'd1);
        cpu_rd_en = 1'b0;

        // Reload held off by a busy CPU
        cpu_idle = 1'b0; load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("busy_valid_drop", 64'(code_valid), 64'd0);
        check("busy_len_hold", 64'(prog_len), 64'd3);
        for (int i = 0; i < 5; i++) begin
            check("busy_not_ready", 64'(in_ready), 64'd0);
            tick();
        end
        cpu_idle = 1'b1;
        check("idle_rise_not_ready", 64'(in_ready), 64'd0);
        tick();
        check("idle_then_ready", 64'(in_ready), 64'd1);

        // Abandon after 2 words, then a 1-word program
        for (int i = 0; i < 2; i++) send(64'hAAAA_0000_0000_0000 + 64'(i), 1'b0);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("restart_not_ready", 64'(in_ready), 64'd0);
        tick();
        send(64'h1111_2222_3333_4444, 1'b1);
        check("len1", 64'(prog_len), 64'd1);
        tick();
        check("len1_valid", 64'(code_valid), 64'd1);

        // Overflow: 16 words with no in_last, 17th refused
        start_load();
        for (int i = 0; i < DEPTH; i++) send(64'hBAD0_0000_0000_0000 + 64'(i), 1'b0);
        check("ovf_err", 64'(load_err), 64'd1);
        check("ovf_len", 64'(prog_len), 64'd0);
        check("ovf_valid", 64'(code_valid), 64'd0);
        check("ovf_not_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b1; in_data = 64'hBAD0_0000_0000_0010;
        tick();
        tick();
        check("ovf_no_write", 64'(ram_wr_en), 64'd0);
        in_valid = 1'b0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("ovf_err_cleared", 64'(load_err), 64'd0);
        tick();

        // Full-depth program with in_last on the final address
        for (int i = 0; i < DEPTH; i++) send(64'hF00D_0000_0000_0000 + 64'(i), i == DEPTH - 1);
        check("len16", 64'(prog_len), 64'd16);
        check("len16_err", 64'(load_err), 64'd0);
        tick();
        check("len16_valid", 64'(code_valid), 64'd1);
        cpu_rd_en = 1'b1; cpu_rd_addr = 4'd15;
        tick();
        check("rd_word15", rd_data, 64'hF00D_0000_0000_000F);
        check("oob_addr15", 64'(fetch_oob), 64'd0);
        cpu_rd_en = 1'b0;

        // load_start collides with an accepted in_last
        start_load();
        send(64'h5555_0000_0000_0000, 1'b0);
        in_valid = 1'b1; in_last = 1'b1; in_data = 64'h5555_0000_0000_0001; load_start = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0; load_start = 1'b0;
        check("collide_valid_t1", 64'(code_valid), 64'd0);
        tick();
        check("collide_valid_t2", 64'(code_valid), 64'd0);
        check("collide_len_hold", 64'(prog_len), 64'd16);

        // Asynchronous reset between edges while a write is in flight
        in_valid = 1'b1; in_data = 64'h7777_0000_0000_0000;
        tick();
        check("pre_reset_write", 64'(ram_wr_en), 64'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async");
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("post_reset_empty", 64'(in_ready), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
